// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC register sequencing and instruction fetch with redirect/trap handling
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [31:0] iv_Pc,
  output logic        o_Pc_Enb,
  output logic [31:0] ov_Pc_Next,
  output logic        o_Imem_Req,
  output logic [31:0] ov_Imem_Addr,
  input  logic        i_Imem_Ack,
  input  logic [31:0] iv_Imem_Rdata,
  output logic        o_Instr_Valid,
  output logic [31:0] ov_Instr,
  output logic [31:0] ov_Instr_Pc,
  input  logic        i_Instr_Ready,
  input  logic        i_Redirect,
  input  logic [31:0] iv_Redirect_Target,
  input  logic        i_Trap,
  output logic        o_Misaligned,
  output logic [31:0] ov_Fetch_Count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        pend, pend_next;
  logic        pend_trap, pend_trap_next;
  logic [31:0] tgt, tgt_next;
  logic [31:0] instr_next, instr_pc_next, count_next;

  logic        flush;
  logic [31:0] flush_tgt;
  logic        keep_trap;

  assign flush     = i_Trap | i_Redirect;
  assign flush_tgt = i_Trap ? TRAP_VECTOR : iv_Redirect_Target;
  // a stored trap outranks any plain redirect that arrives while it waits
  assign keep_trap = pend & pend_trap & ~i_Trap;

  assign o_Instr_Valid = (state == VALID);

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state          <= BOOT;
      pend           <= 1'b0;
      pend_trap      <= 1'b0;
      tgt            <= 32'd0;
      ov_Instr       <= 32'd0;
      ov_Instr_Pc    <= 32'd0;
      ov_Fetch_Count <= 32'd0;
    end else begin
      state          <= state_next;
      pend           <= pend_next;
      pend_trap      <= pend_trap_next;
      tgt            <= tgt_next;
      ov_Instr       <= instr_next;
      ov_Instr_Pc    <= instr_pc_next;
      ov_Fetch_Count <= count_next;
    end
  end

  always_comb begin
    state_next     = state;
    pend_next      = pend;
    pend_trap_next = pend_trap;
    tgt_next       = tgt;
    instr_next     = ov_Instr;
    instr_pc_next  = ov_Instr_Pc;
    count_next     = ov_Fetch_Count;
    o_Pc_Enb       = 1'b0;
    ov_Pc_Next     = 32'd0;
    o_Imem_Req     = 1'b0;
    ov_Imem_Addr   = 32'd0;
    o_Misaligned   = 1'b0;

    case (state)
      BOOT: begin
        // held in BOOT while reset is low; the load only counts once reset lifts
        if (i_Rst) begin
          o_Pc_Enb   = 1'b1;
          ov_Pc_Next = RESET_VECTOR;
        end
        state_next = REQ;
      end

      REQ: begin
        o_Imem_Req   = 1'b1;
        ov_Imem_Addr = iv_Pc;
        if (flush) begin
          pend_next = 1'b1;
          if (!keep_trap) begin
            tgt_next       = flush_tgt;
            pend_trap_next = i_Trap;
          end
        end
        if (i_Imem_Ack) begin
          if (pend || flush) begin
            pend_next  = 1'b0;
            state_next = LOAD;
          end else begin
            instr_next    = iv_Imem_Rdata;
            instr_pc_next = iv_Pc;
            state_next    = VALID;
          end
        end
      end

      VALID: begin
        if (flush) begin
          tgt_next       = flush_tgt;
          pend_trap_next = 1'b0;
          state_next     = LOAD;
        end else if (i_Instr_Ready) begin
          o_Pc_Enb   = 1'b1;
          ov_Pc_Next = ov_Instr_Pc + PC_STEP;
          count_next = ov_Fetch_Count + 32'd1;
          state_next = REQ;
        end
      end

      LOAD: begin
        o_Pc_Enb     = 1'b1;
        ov_Pc_Next   = tgt;
        o_Misaligned = |tgt[1:0];
        state_next   = REQ;
        // the current target is consumed now; a fresh one waits for the next ack
        if (flush) begin
          tgt_next       = flush_tgt;
          pend_trap_next = i_Trap;
          pend_next      = 1'b1;
        end
      end

      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed scoreboard bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_reg = 32'hDEAD_BEEC;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] target = 32'd0;

  logic        pc_enb;
  logic [31:0] pc_next;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned;
  logic [31:0] count;

  logic        mem_en = 1'b1;
  logic        force_ack = 1'b0;
  logic [31:0] force_rdata = 32'd0;
  int          mem_delay = 1;
  int          wait_cnt = 0;
  logic        prev_req = 1'b0;
  int          accepts = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_acc[$];

  pc_fetch_sequencer #(
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR),
    .PC_STEP     (32'd4)
  ) dut (
    .i_Clk             (clk),
    .i_Rst             (rst_n),
    .iv_Pc             (pc_reg),
    .o_Pc_Enb          (pc_enb),
    .ov_Pc_Next        (pc_next),
    .o_Imem_Req        (req),
    .ov_Imem_Addr      (addr),
    .i_Imem_Ack        (ack),
    .iv_Imem_Rdata     (rdata),
    .o_Instr_Valid     (valid),
    .ov_Instr          (instr),
    .ov_Instr_Pc       (instr_pc),
    .i_Instr_Ready     (ready),
    .i_Redirect        (redirect),
    .iv_Redirect_Target(target),
    .i_Trap            (trap),
    .o_Misaligned      (misaligned),
    .ov_Fetch_Count    (count)
  );

  always #5 clk = ~clk;

  // external PC register
  always @(posedge clk) begin
    if (pc_enb) pc_reg <= pc_next;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic respond();
    if (!mem_en) begin
      ack   = force_ack;
      rdata = force_rdata;
    end else if (req && !ack) begin
      if (wait_cnt == mem_delay) begin
        ack      = 1'b1;
        rdata    = mem_word(addr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      ack      = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic monitor();
    logic [31:0] exp_pc;
    if (req && !prev_req && exp_fetch.size() > 0) check("fetch_addr", addr, exp_fetch.pop_front());
    if (req) check("addr_eq_pc", addr, pc_reg);
    prev_req = req;
    if (valid && ready && !redirect && !trap) begin
      exp_pc = 32'hxxxx_xxxx;
      if (exp_acc.size() > 0) exp_pc = exp_acc.pop_front();
      check("accept_pc", instr_pc, exp_pc);
      check("accept_instr", instr, mem_word(exp_pc));
      accepts++;
    end
  endtask

  task automatic tick();
    respond();
    #2;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_accepts(input int n);
    int goal;
    int b;
    goal = accepts + n;
    b = 0;
    while (accepts < goal && b < 200) begin
      tick();
      b++;
    end
    if (accepts < goal) check("accept_timeout", 32'(accepts), 32'(goal));
  endtask

  task automatic wait_valid();
    int b;
    b = 0;
    while (!valid && b < 50) begin
      tick();
      b++;
    end
    if (!valid) check("valid_timeout", 32'(valid), 32'd1);
  endtask

  task automatic wait_load(output logic valid_seen);
    int b;
    b = 0;
    valid_seen = 1'b0;
    while (!pc_enb && b < 50) begin
      if (valid) valid_seen = 1'b1;
      tick();
      b++;
    end
    if (!pc_enb) check("load_timeout", 32'(pc_enb), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b0; redirect = 1'b0; trap = 1'b0;
    mem_en = 1'b1; force_ack = 1'b0;
    #1;
    check("rst_pc_enb", 32'(pc_enb), 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_instr", instr, 32'd0);
    @(posedge clk);
    #1;
    ack = 1'b0; wait_cnt = 0;
    rst_n = 1'b1;
    #1;
    check("boot_pc_enb", 32'(pc_enb), 32'd1);
    check("boot_pc_next", pc_next, RESET_VECTOR);
    exp_fetch.delete(); exp_acc.delete();
    prev_req = 1'b0; accepts = 0;
    tick();
  endtask

  initial begin
    int n;
    logic vseen;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // sequential fetch, 1-cycle ack, ready always high
    do_reset();
    check("pc_after_boot", pc_reg, RESET_VECTOR);
    mem_delay = 1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_fetch.push_back(32'(i * 4));
      exp_acc.push_back(32'(i * 4));
    end
    run_accepts(4);
    check("count_after_4", count, 32'd4);

    // slow memory and stalled decode at 0x10
    mem_delay = 3; ready = 1'b0;
    exp_fetch.push_back(32'h10);
    n = 0;
    for (int b = 0; b < 20 && !valid; b++) begin
      if (req) n++;
      tick();
    end
    check("req_high_cycles", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_instr", instr, mem_word(32'h10));
      check("hold_instr_pc", instr_pc, 32'h10);
      check("hold_pc", pc_reg, 32'h10);
      tick();
    end
    ready = 1'b1;
    exp_acc.push_back(32'h10);
    #1;
    check("accept_pc_enb", 32'(pc_enb), 32'd1);
    check("accept_pc_next", pc_next, 32'h14);
    tick();
    check("pc_after_accept", pc_reg, 32'h14);
    check("count_after_5", count, 32'd5);

    // redirect while the instruction at 0x8 waits in VALID
    do_reset();
    mem_delay = 1; ready = 1'b1;
    exp_fetch.push_back(32'h0); exp_fetch.push_back(32'h4); exp_fetch.push_back(32'h8);
    exp_acc.push_back(32'h0); exp_acc.push_back(32'h4);
    run_accepts(2);
    ready = 1'b0;
    wait_valid();
    check("valid_pc_8", instr_pc, 32'h8);
    redirect = 1'b1; target = 32'h200; ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("redir_valid_drop", 32'(valid), 32'd0);
    check("redir_pc_enb", 32'(pc_enb), 32'd1);
    check("redir_pc_next", pc_next, 32'h200);
    check("redir_req_low", 32'(req), 32'd0);
    check("redir_aligned", 32'(misaligned), 32'd0);
    check("redir_not_counted", count, 32'd2);
    exp_fetch.push_back(32'h200); exp_acc.push_back(32'h200);
    tick();
    check("pc_at_200", pc_reg, 32'h200);
    run_accepts(1);
    check("count_after_redir", count, 32'd3);

    // redirect while waiting for the ack at 0x10
    do_reset();
    mem_delay = 1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_fetch.push_back(32'(i * 4));
      exp_acc.push_back(32'(i * 4));
    end
    run_accepts(4);
    mem_delay = 3;
    exp_fetch.push_back(32'h10);
    redirect = 1'b1; target = 32'h300;
    tick();
    redirect = 1'b0;
    wait_load(vseen);
    check("pend_no_valid", 32'(vseen), 32'd0);
    check("pend_pc_next", pc_next, 32'h300);
    check("pend_req_low", 32'(req), 32'd0);
    check("pend_valid_low", 32'(valid), 32'd0);
    exp_fetch.push_back(32'h300); exp_acc.push_back(32'h300);
    mem_delay = 1;
    tick();
    run_accepts(1);
    check("count_after_pend", count, 32'd5);

    // trap with redirect, then a redirect while the trap is pending
    do_reset();
    mem_delay = 3; ready = 1'b1;
    exp_fetch.push_back(32'h0);
    trap = 1'b1; redirect = 1'b1; target = 32'h400;
    tick();
    trap = 1'b0; target = 32'h500;
    tick();
    redirect = 1'b0;
    wait_load(vseen);
    check("trap_no_valid", 32'(vseen), 32'd0);
    check("trap_pc_next", pc_next, TRAP_VECTOR);
    check("trap_aligned", 32'(misaligned), 32'd0);
    exp_fetch.push_back(TRAP_VECTOR); exp_acc.push_back(TRAP_VECTOR);
    mem_delay = 1;
    tick();
    check("pc_at_trap", pc_reg, TRAP_VECTOR);
    run_accepts(1);

    // misaligned redirect target
    ready = 1'b0;
    exp_fetch.push_back(32'h104);
    wait_valid();
    redirect = 1'b1; target = 32'h202;
    tick();
    redirect = 1'b0;
    check("misaligned_pulse", 32'(misaligned), 32'd1);
    check("misaligned_pc_next", pc_next, 32'h202);
    exp_fetch.push_back(32'h202); exp_acc.push_back(32'h202);
    ready = 1'b1;
    tick();
    check("misaligned_one_cycle", 32'(misaligned), 32'd0);
    check("pc_at_202", pc_reg, 32'h202);
    run_accepts(1);
    check("count_after_trap", count, 32'd2);

    // reset during an outstanding fetch, then a late ack
    do_reset();
    mem_delay = 5;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(req), 32'd0);
    check("midrst_addr", addr, 32'd0);
    check("midrst_pc_enb", 32'(pc_enb), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    mem_en = 1'b0; force_ack = 1'b1; force_rdata = 32'hBAD0_BAD0;
    tick();
    rst_n = 1'b1;
    #1;
    check("late_boot_enb", 32'(pc_enb), 32'd1);
    check("late_boot_next", pc_next, RESET_VECTOR);
    check("late_boot_req", 32'(req), 32'd0);
    tick();
    check("late_ack_ignored", 32'(valid), 32'd0);
    check("late_req", 32'(req), 32'd1);
    check("late_addr", addr, RESET_VECTOR);
    force_ack = 1'b0; mem_en = 1'b1; ack = 1'b0; wait_cnt = 0;
    mem_delay = 1; ready = 1'b1;
    exp_acc.push_back(RESET_VECTOR);
    run_accepts(1);
    check("count_after_late", count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
